obi_wb_bridge: RTL

Responder for the core's OBI-style request/grant/rvalid memory port. It converts each granted OBI transaction into one Wishbone classic cycle toward the Controller bus (`core_*` / `data_mem_*`). One instance sits on the instruction port and one on the data port, between `cv32e41p_core` and `Controller` inside `processorci_top`. A bounded timeout turns a missing Wishbone `ack` into an OBI error response, so the core can never hang.

---
 rtl/processorci_bus_pkg.sv | 20 ++
 rtl/obi_wb_bridge.sv | 106 ++++++++++
 2 files changed

// File: rtl/processorci_bus_pkg.sv
// Shared types and constants for the processorci bus glue (OBI <-> Wishbone).
package processorci_bus_pkg;

  // Bridge FSM: wait for a request, run one Wishbone cycle, emit one response.
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } obi_wb_state_t;

  // Read data returned to the core when the Wishbone side never acknowledges.
  localparam logic [31:0] OBI_WB_ERR_DATA = 32'hDEAD_BEEF;

  // Width of a saturating counter that must hold 0..t; at least one bit so a
  // disabled timeout (t = 0) still yields a legal vector.
  function automatic int unsigned obi_wb_cnt_w(input int unsigned t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/obi_wb_bridge.sv
// OBI request/grant/rvalid responder that turns each granted transaction into
// one Wishbone classic cycle, with a bounded ack timeout that reports an error
// so the core can never hang on a silent slave.
module obi_wb_bridge #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = processorci_bus_pkg::OBI_WB_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // OBI side
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  // Wishbone side
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  wb_ack_i
);
  import processorci_bus_pkg::*;

  localparam int unsigned      CNT_W    = obi_wb_cnt_w(TIMEOUT_CYCLES);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  obi_wb_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  // Grant is purely combinational in IDLE so a request is accepted the same
  // cycle; held low during reset so nothing is accepted that will be dropped.
  assign gnt_o = rst_n & req_i & (state == IDLE);

  // Last waiting cycle reached with no ack; ack takes priority in the FSM.
  assign timeout_hit = TO_EN && (cnt == CNT_LAST);

  // Bridge FSM with all outputs registered; wb_* only load on IDLE->BUSY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            wb_addr_o <= addr_i;
            wb_we_o   <= we_i;
            wb_sel_o  <= be_i;
            wb_data_o <= wdata_i;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            rdata_o  <= wb_we_o ? '0 : wb_data_i;
            err_o    <= 1'b0;
            rvalid_o <= 1'b1;
            state    <= RESP;
          end else if (timeout_hit) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            rdata_o  <= ERR_DATA;
            err_o    <= 1'b1;
            rvalid_o <= 1'b1;
            state    <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // rvalid pulses here for one cycle; rdata/err hold until next response.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
